// File: rtl/uart_rx_int.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) with a FWFT byte FIFO,
// sticky error flags and a level-sensitive interrupt output.
module uart_rx_int #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          RX,
  input  logic                          IE,
  input  logic                          RD_EN,
  input  logic                          CLR_ERR,
  output logic [7:0]                    RD_DATA,
  output logic                          RX_VALID,
  output logic [$clog2(FIFO_DEPTH):0]   RX_COUNT,
  output logic                          FE,
  output logic                          OE,
  output logic                          PE,
  output logic                          UART_INT
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W:0]   CNT_MAX  = (PTR_W + 1)'(FIFO_DEPTH);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd4;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif

  logic             rx_p0, rx_p1, rx_p2;
  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_byte;
  logic             cnt_zero;
  logic             frame_done;
  logic             push_vld;
  logic             fe_set, pe_set, oe_set;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             fifo_empty, fifo_full, pop, wr_ok;
  logic             fe_q, oe_q;

  // Stage p0/p1: two-flop synchronizer; p2: previous sample for falling-edge detect
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
      rx_p2 <= 1'b1;
    end else begin
      rx_p0 <= RX;
      rx_p1 <= rx_p0;
      rx_p2 <= rx_p1;
    end
  end

  assign cnt_zero   = (cnt == '0);
  assign frame_done = (state == STOP) && cnt_zero;

`ifdef UART_RX_PARITY_EN
  logic par_err;
  assign push_vld = frame_done && rx_p1 && !par_err;
  assign pe_set   = frame_done && par_err;
`else
  assign push_vld = frame_done && rx_p1;
  assign pe_set   = 1'b0;
`endif
  assign fe_set = frame_done && !rx_p1;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
      par_err <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (rx_p2 && !rx_p1) begin
            cnt   <= CNT_HALF;
            state <= START;
          end
        end
        START: begin
          if (!cnt_zero) begin
            cnt <= cnt - CNT_ONE;
          end else if (!rx_p1) begin
            cnt     <= CNT_FULL;
            bit_idx <= '0;
            state   <= DATA;
          end else begin
            state <= IDLE;
          end
        end
        DATA: begin
          if (!cnt_zero) begin
            cnt <= cnt - CNT_ONE;
          end else begin
            cnt     <= CNT_FULL;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (!cnt_zero) begin
            cnt <= cnt - CNT_ONE;
          end else begin
            par_err <= ((^shift_byte) != rx_p1);
            cnt     <= CNT_FULL;
            state   <= STOP;
          end
        end
`endif
        STOP: begin
          if (!cnt_zero) begin
            cnt <= cnt - CNT_ONE;
          end else begin
`ifdef UART_RX_PARITY_EN
            par_err <= 1'b0;
`endif
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data bits land LSB first; the byte register carries no reset
  always_ff @(posedge CLK) begin
    if ((state == DATA) && cnt_zero)
      shift_byte[bit_idx] <= rx_p1;
  end

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_MAX);
  assign pop        = RD_EN && !fifo_empty;
  // A full FIFO still accepts the byte when the head leaves in the same cycle
  assign wr_ok      = push_vld && (!fifo_full || pop);
  assign oe_set     = push_vld && fifo_full && !RD_EN;

  always_ff @(posedge CLK) begin
    if (wr_ok)
      mem[wr_ptr] <= shift_byte;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_ok, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky flags: a set event in the clear cycle wins
  always_ff @(posedge CLK) begin
    if (RESET) begin
      fe_q <= 1'b0;
      oe_q <= 1'b0;
    end else begin
      fe_q <= (fe_q && !CLR_ERR) || fe_set;
      oe_q <= (oe_q && !CLR_ERR) || oe_set;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic pe_q;
  always_ff @(posedge CLK) begin
    if (RESET)
      pe_q <= 1'b0;
    else
      pe_q <= (pe_q && !CLR_ERR) || pe_set;
  end
  assign PE = pe_q;
`else
  assign PE = pe_set;
`endif

  assign FE       = fe_q;
  assign OE       = oe_q;
  assign RD_DATA  = fifo_empty ? 8'h00 : mem[rd_ptr];
  assign RX_VALID = !fifo_empty;
  assign RX_COUNT = count;
  assign UART_INT = IE && RX_VALID;

endmodule
